regfile_scoreboard: RTL and testbench

Issue-side scoreboard for the 15-entry register file. Tracks how many in-flight instructions will write each register, holds the issue stage when a source operand or destination is unsafe, and retires pending writes as the writeback stage commits them. Sits between decode/issue and the register file's write port. Replaces per-stage hazard comparison with a per-register pending count, so pipeline depth can grow without changing the hazard logic.

---
 rtl/regfile_pkg.sv | 7 +
 rtl/regfile_scoreboard_sb_counter.sv | 21 ++
 rtl/regfile_scoreboard.sv | 67 ++++++
 tb/tb_regfile_scoreboard.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths and indices for the issue scoreboard
package regfile_pkg;
    localparam int REG_ADDR_W = 4;
    localparam int NUM_REGS = 15;
    localparam int CNT_W = 2;
    localparam logic [REG_ADDR_W-1:0] PC_IDX = 4'hF;
endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// sb_counter: per-register pending-write up/down counter with zero/full flags
module sb_counter #(
    parameter int CNT_W = regfile_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o,
    output logic             full_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (inc_i && !dec_i) ? cnt_q + CNT_W'(1) :
                        (dec_i && !inc_i) ? cnt_q - CNT_W'(1) : cnt_q;
    always_ff @(posedge clk)
        cnt_q <= rst ? '0 : cnt_d;
    assign cnt_o = cnt_q;
    assign zero_o = cnt_q == '0;
    assign full_o = &cnt_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write counts gating issue, retired at writeback
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int CNT_W = regfile_pkg::CNT_W,
    parameter int STALL_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid_i,
    input  logic [REG_ADDR_W-1:0] src1_i,
    input  logic [REG_ADDR_W-1:0] src2_i,
    input  logic                  two_src_i,
    input  logic [REG_ADDR_W-1:0] dest_i,
    input  logic                  issue_wb_en_i,
    output logic                  issue_ready_o,
    input  logic                  wb_en_i,
    input  logic [REG_ADDR_W-1:0] dest_wb_i,
    output logic [NUM_REGS-1:0]   pending_mask_o,
    output logic [STALL_W-1:0]    stall_count_o,
    output logic                  wb_err_o
);
    localparam int NA = 2**REG_ADDR_W;
    // Vectors span the full address space; untracked indices (PC) read as idle.
    logic [NA-1:0] busy, full_blk, zero_any;
    logic [NUM_REGS-1:0] wb_hit, inc, dec, zero, full;
    logic [CNT_W-1:0] cnt [NUM_REGS];
    logic fire, dest_full;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic wb_err_q, wb_err_d;
    assign busy[NA-1:NUM_REGS] = '0;
    assign full_blk[NA-1:NUM_REGS] = '0;
    assign zero_any[NA-1:NUM_REGS] = '0;
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        assign wb_hit[i] = wb_en_i && dest_wb_i == REG_ADDR_W'(i);
        assign inc[i] = fire && issue_wb_en_i && dest_i == REG_ADDR_W'(i);
        assign dec[i] = wb_hit[i] && !zero[i];
        // A single pending write landing this cycle is already visible to the read.
        assign busy[i] = cnt[i] > CNT_W'(1) || (cnt[i] == CNT_W'(1) && !wb_hit[i]);
        assign full_blk[i] = full[i] && !wb_hit[i];
        assign zero_any[i] = zero[i];
        assign pending_mask_o[i] = !zero[i];
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .inc_i  (inc[i]),
            .dec_i  (dec[i]),
            .cnt_o  (cnt[i]),
            .zero_o (zero[i]),
            .full_o (full[i])
        );
    end
    assign dest_full = issue_wb_en_i && full_blk[dest_i];
    assign issue_ready_o = !busy[src1_i] && !(two_src_i && busy[src2_i]) && !dest_full;
    assign fire = issue_valid_i && issue_ready_o;
    always_comb begin
        stall_d = (issue_valid_i && !issue_ready_o && !(&stall_q)) ? stall_q + STALL_W'(1) : stall_q;
        wb_err_d = wb_err_q || (wb_en_i && zero_any[dest_wb_i]);
    end
    always_ff @(posedge clk) begin
        stall_q <= rst ? '0 : stall_d;
        wb_err_q <= rst ? 1'b0 : wb_err_d;
    end
    assign stall_count_o = stall_q;
    assign wb_err_o = wb_err_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed scenario tasks for the issue scoreboard
module tb_regfile_scoreboard;
    logic clk = 1'b0, rst = 1'b1;
    logic issue_valid, two_src, issue_wb_en, wb_en, issue_ready, wb_err;
    logic [3:0] src1, src2, dest, dest_wb;
    logic [14:0] pending_mask;
    logic [15:0] stall_count;
    int total = 0, bad = 0;
    logic [15:0] exp_stall = '0;
    always #5 clk = ~clk;
    regfile_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid_i  (issue_valid),
        .src1_i         (src1),
        .src2_i         (src2),
        .two_src_i      (two_src),
        .dest_i         (dest),
        .issue_wb_en_i  (issue_wb_en),
        .issue_ready_o  (issue_ready),
        .wb_en_i        (wb_en),
        .dest_wb_i      (dest_wb),
        .pending_mask_o (pending_mask),
        .stall_count_o  (stall_count),
        .wb_err_o       (wb_err)
    );
    task automatic idle();
        issue_valid = 0; two_src = 0; issue_wb_en = 0; wb_en = 0;
        src1 = 0; src2 = 0; dest = 0; dest_wb = 0;
        #1;
    endtask
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic issue(input logic [3:0] s1, input logic [3:0] s2, input logic two, input logic [3:0] d, input logic we);
        issue_valid = 1; src1 = s1; src2 = s2; two_src = two; dest = d; issue_wb_en = we;
        #1;
    endtask
    task automatic test_reset();
        rst = 1; idle(); tick(); rst = 0; #1;
        total++; if (pending_mask !== 15'h0) begin bad++; $display("FAIL reset_mask got=%h exp=0", pending_mask); end
        total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_count); end
        total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", wb_err); end
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", issue_ready); end
    endtask
    task automatic test_issue();
        issue(4'd2, 4'd3, 1, 4'd4, 1);
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL issue_ready got=%b exp=1", issue_ready); end
        tick(); idle();
        total++; if (pending_mask !== 15'h0010) begin bad++; $display("FAIL issue_mask got=%h exp=0010", pending_mask); end
    endtask
    task automatic test_stall();
        issue(4'd4, 4'd0, 0, 4'd0, 0);
        for (int c = 0; c < 3; c++) begin
            total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL stall_ready cyc=%0d got=%b exp=0", c, issue_ready); end
            tick(); exp_stall++;
        end
        total++; if (stall_count !== exp_stall) begin bad++; $display("FAIL stall_count got=%0d exp=%0d", stall_count, exp_stall); end
        wb_en = 1; dest_wb = 4'd4; #1;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%b exp=1", issue_ready); end
        tick(); idle();
        total++; if (pending_mask !== 15'h0) begin bad++; $display("FAIL stall_mask got=%h exp=0", pending_mask); end
        total++; if (stall_count !== exp_stall) begin bad++; $display("FAIL stall_hold got=%0d exp=%0d", stall_count, exp_stall); end
    endtask
    task automatic test_waw();
        for (int c = 0; c < 3; c++) begin
            issue(4'd0, 4'd0, 0, 4'd5, 1);
            total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL waw_ready cyc=%0d got=%b exp=1", c, issue_ready); end
            tick();
        end
        issue(4'd0, 4'd0, 0, 4'd5, 1);
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL waw_full got=%b exp=0", issue_ready); end
        tick(); exp_stall++;
        wb_en = 1; dest_wb = 4'd5; #1;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL waw_wb_release got=%b exp=1", issue_ready); end
        tick(); idle();
        issue(4'd0, 4'd0, 0, 4'd5, 1);
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL waw_still_full got=%b exp=0", issue_ready); end
        idle();
        wb_en = 1; dest_wb = 4'd5; #1;
        tick(); tick(); idle();
        total++; if (pending_mask !== 15'h0020) begin bad++; $display("FAIL waw_drain2 got=%h exp=0020", pending_mask); end
        wb_en = 1; dest_wb = 4'd5; #1;
        tick(); idle();
        total++; if (pending_mask !== 15'h0) begin bad++; $display("FAIL waw_drain3 got=%h exp=0", pending_mask); end
        total++; if (stall_count !== exp_stall) begin bad++; $display("FAIL waw_stall got=%0d exp=%0d", stall_count, exp_stall); end
    endtask
    task automatic test_back_to_back();
        issue(4'd0, 4'd0, 0, 4'd6, 1);
        tick();
        wb_en = 1; dest_wb = 4'd6; #1;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", issue_ready); end
        tick(); idle();
        total++; if (pending_mask !== 15'h0040) begin bad++; $display("FAIL b2b_mask got=%h exp=0040", pending_mask); end
        wb_en = 1; dest_wb = 4'd6; #1;
        tick(); idle();
        total++; if (pending_mask !== 15'h0) begin bad++; $display("FAIL b2b_drain got=%h exp=0", pending_mask); end
        total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL b2b_err got=%b exp=0", wb_err); end
    endtask
    task automatic test_pc();
        issue(4'd0, 4'd0, 0, 4'd9, 1);
        tick();
        issue(4'd15, 4'd15, 1, 4'd15, 1);
        wb_en = 1; dest_wb = 4'd15; #1;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL pc_ready got=%b exp=1", issue_ready); end
        tick(); idle();
        total++; if (pending_mask !== 15'h0200) begin bad++; $display("FAIL pc_mask got=%h exp=0200", pending_mask); end
        total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL pc_err got=%b exp=0", wb_err); end
        total++; if (stall_count !== exp_stall) begin bad++; $display("FAIL pc_stall got=%0d exp=%0d", stall_count, exp_stall); end
    endtask
    task automatic test_wb_err();
        wb_en = 1; dest_wb = 4'd7; #1;
        total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL err_before got=%b exp=0", wb_err); end
        tick(); idle();
        total++; if (wb_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", wb_err); end
        issue(4'd0, 4'd0, 0, 4'd8, 1);
        tick(); idle();
        wb_en = 1; dest_wb = 4'd8; #1;
        tick(); idle();
        total++; if (wb_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", wb_err); end
        total++; if (pending_mask !== 15'h0200) begin bad++; $display("FAIL err_mask got=%h exp=0200", pending_mask); end
    endtask
    task automatic test_reset_mid_stall();
        issue(4'd9, 4'd0, 0, 4'd0, 0);
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL mid_ready got=%b exp=0", issue_ready); end
        tick(); exp_stall++;
        total++; if (stall_count !== exp_stall) begin bad++; $display("FAIL mid_stall got=%0d exp=%0d", stall_count, exp_stall); end
        rst = 1; wb_en = 1; dest_wb = 4'd7; #1;
        tick(); rst = 0; #1;
        total++; if (pending_mask !== 15'h0) begin bad++; $display("FAIL mid_mask got=%h exp=0", pending_mask); end
        total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL mid_stall_clr got=%0d exp=0", stall_count); end
        total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL mid_err got=%b exp=0", wb_err); end
        idle(); issue(4'd9, 4'd0, 0, 4'd0, 0);
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_after got=%b exp=1", issue_ready); end
        idle();
    endtask
    initial begin
        idle();
        @(negedge clk);
        test_reset();
        test_issue();
        test_stall();
        test_waw();
        test_back_to_back();
        test_pc();
        test_wb_err();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
